// File: rtl/mux4_pkg.sv
// rtl/mux4_pkg.sv - shared select encoding and default counter width for mux4_dual_compare
package mux4_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/mux_nand.sv
// rtl/mux_nand.sv - 4:1 mux built only from NAND primitives
module mux_nand (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic select0,
    input  logic select1,
    output wire  out
);

    wire n_s0;
    wire n_s1;
    wire term_a;
    wire term_b;
    wire term_c;
    wire term_d;

    // Inverters are NANDs with both inputs tied together.
    nand u_inv_s0 (n_s0, select0, select0);
    nand u_inv_s1 (n_s1, select1, select1);

    nand u_term_a (term_a, a, n_s1, n_s0);
    nand u_term_b (term_b, b, n_s1, select0);
    nand u_term_c (term_c, c, select1, n_s0);
    nand u_term_d (term_d, d, select1, select0);

    nand u_sum (out, term_a, term_b, term_c, term_d);

endmodule

// File: rtl/mux_tri_state.sv
// rtl/mux_tri_state.sv - 4:1 mux as one-hot decoder driving bufif1 buffers onto a shared net
module mux_tri_state
    import mux4_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic select0,
    input  logic select1,
    output wire  out
);

    wire [1:0] sel;
    wire [3:0] en;
    wire       shared_net;

    assign sel = {select1, select0};

    // One-hot enables: exactly one driver owns the net for any known select.
    assign en[0] = (sel == SEL_A);
    assign en[1] = (sel == SEL_B);
    assign en[2] = (sel == SEL_C);
    assign en[3] = (sel == SEL_D);

    bufif1 u_drv_a (shared_net, a, en[0]);
    bufif1 u_drv_b (shared_net, b, en[1]);
    bufif1 u_drv_c (shared_net, c, en[2]);
    bufif1 u_drv_d (shared_net, d, en[3]);

    assign out = shared_net;

endmodule

// File: rtl/mux4_dual_compare.sv
// rtl/mux4_dual_compare.sv - NAND and tri-state 4:1 muxes with a registered equivalence checker
module mux4_dual_compare
    import mux4_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             select0,
    input  logic             select1,
    output logic             out_nand,
    output logic             out_tri_state,
    output logic             out_q,
    output logic             mismatch,
    output logic             mismatch_sticky,
    output logic [CNT_W-1:0] mismatch_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic diff;

    mux_nand u_mux_nand (
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .select0 (select0),
        .select1 (select1),
        .out     (out_nand)
    );

    mux_tri_state u_mux_tri_state (
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .select0 (select0),
        .select1 (select1),
        .out     (out_tri_state)
    );

    assign diff = (out_nand != out_tri_state);

    // Reset wins over a same-edge mismatch; the counter holds at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q           <= 1'b0;
            mismatch        <= 1'b0;
            mismatch_sticky <= 1'b0;
            mismatch_cnt    <= '0;
        end else begin
            out_q    <= out_nand;
            mismatch <= diff;
            if (diff) begin
                mismatch_sticky <= 1'b1;
                if (mismatch_cnt != CNT_MAX) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux4_dual_compare.sv
// tb/tb_mux4_dual_compare.sv - directed self-checking bench for mux4_dual_compare
module tb_mux4_dual_compare;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a, b, c, d, select0, select1;

    logic       out_nand, out_tri_state, out_q, mismatch, mismatch_sticky;
    logic [7:0] mismatch_cnt;

    logic       s_out_nand, s_out_tri_state, s_out_q, s_mismatch, s_mismatch_sticky;
    logic [1:0] s_mismatch_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux4_dual_compare #(.CNT_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .a               (a),
        .b               (b),
        .c               (c),
        .d               (d),
        .select0         (select0),
        .select1         (select1),
        .out_nand        (out_nand),
        .out_tri_state   (out_tri_state),
        .out_q           (out_q),
        .mismatch        (mismatch),
        .mismatch_sticky (mismatch_sticky),
        .mismatch_cnt    (mismatch_cnt)
    );

    mux4_dual_compare #(.CNT_W(2)) dut_sat (
        .clk             (clk),
        .rst_n           (rst_n),
        .a               (a),
        .b               (b),
        .c               (c),
        .d               (d),
        .select0         (select0),
        .select1         (select1),
        .out_nand        (s_out_nand),
        .out_tri_state   (s_out_tri_state),
        .out_q           (s_out_q),
        .mismatch        (s_mismatch),
        .mismatch_sticky (s_mismatch_sticky),
        .mismatch_cnt    (s_mismatch_cnt)
    );

    task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [5:0] v);
        {a, b, c, d, select1, select0} = v;
        #1;
    endtask

    task automatic chk_comb(input string tag, input logic expected);
        chk({tag, "_nand"}, {7'd0, out_nand}, {7'd0, expected});
        chk({tag, "_tri"}, {7'd0, out_tri_state}, {7'd0, expected});
    endtask

    initial begin
        logic expv;
        rst_n = 1'b0;
        set_in(6'b000000);
        tick();
        tick();
        rst_n = 1'b1;

        // {a,b,c,d,s1,s0}: sel=00, c=1
        set_in(6'b001000);
        chk_comb("rst_sel00", 1'b0);
        chk("rst_out_q", {7'd0, out_q}, 8'd0);
        chk("rst_mismatch", {7'd0, mismatch}, 8'd0);
        chk("rst_sticky", {7'd0, mismatch_sticky}, 8'd0);
        chk("rst_cnt", mismatch_cnt, 8'd0);

        set_in(6'b101000);
        chk_comb("a_rise", 1'b1);
        chk("a_rise_q_before", {7'd0, out_q}, 8'd0);
        tick();
        chk("a_rise_q_after", {7'd0, out_q}, 8'd1);
        set_in(6'b001000);
        chk_comb("a_fall", 1'b0);
        tick();
        chk("a_fall_q_after", {7'd0, out_q}, 8'd0);

        set_in(6'b001010);
        chk_comb("sel10_c1", 1'b1);
        set_in(6'b000010);
        chk_comb("sel10_c0", 1'b0);
        set_in(6'b001010);
        chk_comb("sel10_c1b", 1'b1);
        set_in(6'b111110);
        chk_comb("sel10_others1", 1'b1);
        set_in(6'b001010);
        set_in(6'b001011);
        chk_comb("sel11_d0", 1'b0);
        set_in(6'b001010);
        chk_comb("sel10_back", 1'b1);
        tick();
        chk("sel10_q", {7'd0, out_q}, 8'd1);

        for (int i = 0; i < 64; i++) begin
            logic [5:0] v;
            v = 6'(i);
            case (v[1:0])
                2'b00:   expv = v[5];
                2'b01:   expv = v[4];
                2'b10:   expv = v[3];
                default: expv = v[2];
            endcase
            set_in(v);
            chk_comb($sformatf("sweep%0d", i), expv);
            tick();
            chk($sformatf("sweep%0d_q", i), {7'd0, out_q}, {7'd0, expv});
            chk($sformatf("sweep%0d_mm", i), {7'd0, mismatch}, 8'd0);
        end
        chk("sweep_cnt", mismatch_cnt, 8'd0);
        chk("sweep_sticky", {7'd0, mismatch_sticky}, 8'd0);

        // sel=00, a=1: the true output is 1, so forcing 0 creates a mismatch
        set_in(6'b100000);
        force dut.out_tri_state = 1'b0;
        #1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("fault_mm%0d", k), {7'd0, mismatch}, 8'd1);
            chk($sformatf("fault_cnt%0d", k), mismatch_cnt, 8'(k));
            chk($sformatf("fault_sticky%0d", k), {7'd0, mismatch_sticky}, 8'd1);
        end
        rst_n = 1'b0;
        tick();
        chk("fault_rst_mm", {7'd0, mismatch}, 8'd0);
        chk("fault_rst_cnt", mismatch_cnt, 8'd0);
        chk("fault_rst_sticky", {7'd0, mismatch_sticky}, 8'd0);
        release dut.out_tri_state;
        rst_n = 1'b1;
        #1;
        tick();
        chk("post_release_mm", {7'd0, mismatch}, 8'd0);
        chk("post_release_cnt", mismatch_cnt, 8'd0);

        force dut_sat.out_tri_state = 1'b0;
        #1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("sat_cnt%0d", k), {6'd0, s_mismatch_cnt}, (k < 3) ? 8'(k) : 8'd3);
        end
        release dut_sat.out_tri_state;
        #1;
        tick();
        chk("sat_hold", {6'd0, s_mismatch_cnt}, 8'd3);
        chk("sat_mm_clear", {7'd0, s_mismatch}, 8'd0);
        chk("sat_sticky", {7'd0, s_mismatch_sticky}, 8'd1);
        chk("main_untouched", mismatch_cnt, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
